// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              DM_req_OUT;
    logic              DM_we_OUT;
    logic [ADDR_W-1:0] DM_addr_OUT;
    logic [31:0]       DM_wdata_OUT;
    logic [3:0]        DM_be_OUT;
    logic [31:0]       DM_rdata_IN;
    logic              DM_ack_IN;

    modport master (
        output DM_req_OUT, DM_we_OUT, DM_addr_OUT, DM_wdata_OUT, DM_be_OUT,
        input  DM_rdata_IN, DM_ack_IN
    );

    modport slave (
        input  DM_req_OUT, DM_we_OUT, DM_addr_OUT, DM_wdata_OUT, DM_be_OUT,
        output DM_rdata_IN, DM_ack_IN
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: handshaked data-memory access with byte enables, selectable
// endianness, alignment/timeout exceptions, registered writeback and forwarding.
module mem_access_unit #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned ALIGN_CHECK    = 1,
    parameter int unsigned LITTLE_ENDIAN  = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       Instr1_PC_IN,
    input  logic [ADDR_W-1:0] ALU_result1_IN,
    input  logic [31:0]       MemWriteData1_IN,
    input  logic [4:0]        WriteRegister1_IN,
    input  logic              RegWrite1_IN,
    input  logic [5:0]        ALU_Control1_IN,
    input  logic              MemRead1_IN,
    input  logic              MemWrite1_IN,
    output logic [4:0]        WriteRegister1_OUT,
    output logic              RegWrite1_OUT,
    output logic [31:0]       WriteData1_OUT,
    output logic [1:0]        Exception_OUT,
    output logic [31:0]       ExceptionPC_OUT,
    output logic              STALL_OUT,
    output logic [31:0]       MEM_Data_Forward,
    mem_access_unit_if.master dm
);
    localparam logic [5:0] OP_LB  = 6'b100001, OP_LBU = 6'b101010, OP_LH  = 6'b101011,
                           OP_LHU = 6'b101100, OP_LWL = 6'b101101, OP_LWR = 6'b101110,
                           OP_SB  = 6'b101111, OP_SH  = 6'b110000, OP_SC  = 6'b110110,
                           OP_SWL = 6'b110010, OP_SWR = 6'b110011;

    typedef enum logic [2:0] {
        ACC_WORD, ACC_BYTE, ACC_BYTEU, ACC_HALF, ACC_HALFU, ACC_LEFT, ACC_RIGHT
    } access_t;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    access_t     acc;
    logic        is_load, is_store, is_mem, is_sc, fault;
    logic        go, req, ack_hit, stall, timeout_now;
    logic [1:0]  off_raw, off, pos, pos_h, pos_r;
    logic [3:0]  be;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] rt, rdata, wdata, load_val, wb_val, alu32, fwd;

    always_comb begin
        is_store = MemWrite1_IN;
        is_load  = MemRead1_IN && !MemWrite1_IN;
        is_mem   = is_store || is_load;
        is_sc    = 1'b0;
        acc      = ACC_WORD;
        if (is_store) begin
            case (ALU_Control1_IN)
                OP_SB:   acc = ACC_BYTE;
                OP_SH:   acc = ACC_HALF;
                OP_SWL:  acc = ACC_LEFT;
                OP_SWR:  acc = ACC_RIGHT;
                OP_SC:   is_sc = 1'b1;
                default: acc = ACC_WORD;
            endcase
        end else if (is_load) begin
            case (ALU_Control1_IN)
                OP_LB:   acc = ACC_BYTE;
                OP_LBU:  acc = ACC_BYTEU;
                OP_LH:   acc = ACC_HALF;
                OP_LHU:  acc = ACC_HALFU;
                OP_LWL:  acc = ACC_LEFT;
                OP_LWR:  acc = ACC_RIGHT;
                default: acc = ACC_WORD;
            endcase
        end

        // Offsets are forced aligned so the no-check build silently ignores low bits.
        off_raw = ALU_result1_IN[1:0];
        off     = off_raw;
        fault   = 1'b0;
        case (acc)
            ACC_HALF, ACC_HALFU: begin fault = off_raw[0];        off = {off_raw[1], 1'b0}; end
            ACC_WORD:            begin fault = (off_raw != 2'b00); off = 2'b00;              end
            default: ;
        endcase
        if (ALIGN_CHECK == 0) fault = 1'b0;
        fault = fault && is_mem;

        // pos is the big-endian byte position; little-endian mirrors it.
        pos   = (LITTLE_ENDIAN != 0) ? ~off : off;
        pos_h = {pos[1], 1'b0};
        pos_r = 2'd3 - pos;

        rt = MemWriteData1_IN;
        case (acc)
            ACC_BYTE, ACC_BYTEU: begin be = 4'b1000 >> pos;   wdata = {4{rt[7:0]}};           end
            ACC_HALF, ACC_HALFU: begin be = 4'b1100 >> pos_h; wdata = {2{rt[15:0]}};          end
            ACC_LEFT:            begin be = 4'b1111 >> pos;   wdata = rt >> {pos, 3'b000};    end
            ACC_RIGHT:           begin be = 4'b1111 << pos_r; wdata = rt << {pos_r, 3'b000};  end
            default:             begin be = 4'b1111;          wdata = rt;                     end
        endcase

        rdata     = dm.DM_rdata_IN;
        lane_byte = rdata[{pos_r, 3'b000} +: 8];
        lane_half = pos_h[1] ? rdata[15:0] : rdata[31:16];
        case (acc)
            ACC_BYTE:  load_val = {{24{lane_byte[7]}}, lane_byte};
            ACC_BYTEU: load_val = {24'b0, lane_byte};
            ACC_HALF:  load_val = {{16{lane_half[15]}}, lane_half};
            ACC_HALFU: load_val = {16'b0, lane_half};
            ACC_LEFT: begin
                case (pos)
                    2'd0:    load_val = rdata;
                    2'd1:    load_val = {rdata[23:0], rt[7:0]};
                    2'd2:    load_val = {rdata[15:0], rt[15:0]};
                    default: load_val = {rdata[7:0], rt[23:0]};
                endcase
            end
            ACC_RIGHT: begin
                case (pos)
                    2'd0:    load_val = {rt[31:8], rdata[31:24]};
                    2'd1:    load_val = {rt[31:16], rdata[31:16]};
                    2'd2:    load_val = {rt[31:24], rdata[31:8]};
                    default: load_val = rdata;
                endcase
            end
            default: load_val = rdata;
        endcase

        alu32  = 32'(ALU_result1_IN);
        wb_val = is_load ? load_val : (is_sc ? 32'd1 : alu32);

        go          = is_mem && !fault;
        req         = (state == BUSY) || go;
        timeout_now = (state == BUSY) && !dm.DM_ack_IN && (cnt == CNT_W'(TIMEOUT_CYCLES));
        ack_hit     = req && dm.DM_ack_IN;
        stall       = req && !dm.DM_ack_IN && !timeout_now;
        fwd         = ack_hit ? wb_val : alu32;
    end

    // Reset gates every combinational output so an in-flight access drops at once.
    assign dm.DM_req_OUT   = RESET && req;
    assign dm.DM_we_OUT    = RESET && req && is_store;
    assign dm.DM_addr_OUT  = (RESET && req) ? {ALU_result1_IN[ADDR_W-1:2], 2'b00} : '0;
    assign dm.DM_be_OUT    = (RESET && req) ? be : '0;
    assign dm.DM_wdata_OUT = (RESET && req && is_store) ? wdata : '0;
    assign STALL_OUT        = RESET && stall;
    assign MEM_Data_Forward = RESET ? fwd : '0;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state              <= IDLE;
            cnt                <= '0;
            WriteRegister1_OUT <= '0;
            RegWrite1_OUT      <= 1'b0;
            WriteData1_OUT     <= '0;
            Exception_OUT      <= '0;
            ExceptionPC_OUT    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fault) begin
                        WriteRegister1_OUT <= WriteRegister1_IN;
                        RegWrite1_OUT      <= 1'b0;
                        WriteData1_OUT     <= fwd;
                        Exception_OUT      <= is_store ? 2'b10 : 2'b01;
                        ExceptionPC_OUT    <= Instr1_PC_IN;
                    end else if (go && !dm.DM_ack_IN) begin
                        state         <= BUSY;
                        cnt           <= CNT_W'(1);
                        RegWrite1_OUT <= 1'b0;
                        Exception_OUT <= '0;
                    end else begin
                        WriteRegister1_OUT <= WriteRegister1_IN;
                        RegWrite1_OUT      <= RegWrite1_IN;
                        WriteData1_OUT     <= fwd;
                        Exception_OUT      <= '0;
                    end
                end
                BUSY: begin
                    if (dm.DM_ack_IN) begin
                        state              <= IDLE;
                        cnt                <= '0;
                        WriteRegister1_OUT <= WriteRegister1_IN;
                        RegWrite1_OUT      <= RegWrite1_IN;
                        WriteData1_OUT     <= fwd;
                        Exception_OUT      <= '0;
                    end else if (timeout_now) begin
                        state              <= IDLE;
                        cnt                <= '0;
                        WriteRegister1_OUT <= WriteRegister1_IN;
                        RegWrite1_OUT      <= 1'b0;
                        Exception_OUT      <= 2'b11;
                        ExceptionPC_OUT    <= Instr1_PC_IN;
                    end else begin
                        cnt           <= cnt + 1'b1;
                        RegWrite1_OUT <= 1'b0;
                        Exception_OUT <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor of the MIPS MEM stage; sits between the EX/MEM and MEM/WB pipeline registers.
- Drives the data memory through a req/ack handshake, so memory may take any number of cycles to respond.
- Stalls the pipeline while a memory access is outstanding.
- Writes use byte enables, not read-modify-write; selectable endianness; alignment-fault and bus-timeout detection.
- Registers the writeback tuple and provides a combinational forwarding value.

Parameters:
- ADDR_W, 32: address width.
- TIMEOUT_CYCLES, 255: max BUSY cycles without ack before a bus error is raised; must be ≥1.
- CNT_W, 8: wait-counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- ALIGN_CHECK, 1: 1 = raise address errors on misaligned halfword/word ops; 0 = ignore addr low bits and force alignment.
- LITTLE_ENDIAN, 0: 0 = big-endian lanes (offset 0 = bits[31:24]); 1 = little-endian (offset 0 = bits[7:0]).

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset; asynchronous, active-low.
- Instr1_PC_IN  in  32  PC of the op, captured for exceptions.
- ALU_result1_IN  in  ADDR_W  effective address, or the result for non-memory ops.
- MemWriteData1_IN  in  32  store data; also the old rt value for LWL/LWR.
- WriteRegister1_IN  in  5  destination register.
- RegWrite1_IN  in  1  op writes a register.
- ALU_Control1_IN  in  6  op code (codebase encodings).
- MemRead1_IN  in  1  load request.
- MemWrite1_IN  in  1  store request.
- WriteRegister1_OUT  out  5  registered destination.
- RegWrite1_OUT  out  1  registered write enable.
- WriteData1_OUT  out  32  registered writeback data.
- Exception_OUT  out  2  00 none, 01 AdEL, 10 AdES, 11 bus timeout.
- ExceptionPC_OUT  out  32  PC of the faulting op.
- STALL_OUT  out  1  freeze upstream stages.
- MEM_Data_Forward  out  32  combinational value that WriteData1_OUT will take at the next completing edge.
- DM_req_OUT  out  1  memory request.
- DM_we_OUT  out  1  1 = write.
- DM_addr_OUT  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- DM_wdata_OUT  out  32  lane-positioned write data.
- DM_be_OUT  out  4  byte enables; bit3 = bits[31:24].
- DM_rdata_IN  in  32  read data; valid when DM_ack_IN is high.
- DM_ack_IN  in  1  access complete.

Behaviour:

Reset:
- All outputs 0; FSM to IDLE; counter 0.
- Asserting reset during BUSY drops DM_req_OUT immediately; the pending access is abandoned.

Op decoding:
- Loads: LW=111101, LL=101000, LWC1=110101, LB=100001, LH=101011, LBU=101010, LHU=101100, LWL=101101, LWR=101110.
- Stores: SB=101111, SH=110000, SW=110001, SC=110110, SWL=110010, SWR=110011.
- MemWrite1_IN has priority over MemRead1_IN.
- An unknown code with MemRead1_IN is treated as LW; with MemWrite1_IN, as SW.

Alignment faults (ALIGN_CHECK=1):
- Half ops fault on addr[0]=1; word ops (LW/LL/LWC1/SW/SC) fault on addr[1:0]≠0.
- Byte ops and LWL/LWR/SWL/SWR never fault.
- A fault issues no request and completes at the next edge: Exception_OUT=01 (load) or 10 (store), RegWrite1_OUT=0, ExceptionPC_OUT=Instr1_PC_IN.

Non-memory ops:
- No request; 1-cycle latency.
- WriteData1_OUT=ALU_result1_IN.

FSM IDLE:
- For a valid memory op, DM_req_OUT=1 combinationally.
- If DM_ack_IN is high in the same cycle, the op completes at that edge with no stall.
- Otherwise STALL_OUT=1, go to BUSY, counter=1.

FSM BUSY:
- DM_req_OUT, address, enables and data held (upstream holds its inputs stable under stall); STALL_OUT=1.
- Counter increments each cycle without ack.
- On DM_ack_IN: complete, go to IDLE, STALL_OUT=0 in that cycle.
- When counter==TIMEOUT_CYCLES without ack: drop req, Exception_OUT=11, RegWrite1_OUT=0, go to IDLE.

Output registers:
- Update only on completion edges.
- On stalled edges they load a bubble: RegWrite1_OUT=0, Exception_OUT=00.

Store lanes (big-endian, off = addr[1:0]):
- SB: be=1000>>off; data = byte replicated ×4.
- SH: off0 → be 1100; off2 → be 0011; data = half replicated.
- SW/SC: be 1111.
- SWL: be=1111>>off; wdata=rt>>(8·off).
- SWR: be=1111<<(3−off) (4-bit); wdata=rt<<(8·(3−off)).
- SC always succeeds: writeback value is 1.

Load extraction (big-endian):
- LB/LBU: lane off, sign- or zero-extended.
- LH/LHU: off0 → bits[31:16]; off2 → bits[15:0].
- LWL: off0 → mem; off1 → {mem[23:0],rt[7:0]}; off2 → {mem[15:0],rt[15:0]}; off3 → {mem[7:0],rt[23:0]}.
- LWR: off3 → mem; off0 → {rt[31:8],mem[31:24]}; off1 → {rt[31:16],mem[31:16]}; off2 → {rt[31:24],mem[31:8]}.

LITTLE_ENDIAN=1:
- Lane index becomes 3−off for all byte/half selects and enables.
- LWL/LWR/SWL/SWR mirror accordingly.

Forwarding:
- MEM_Data_Forward = extracted load data when ack is high, otherwise ALU_result1_IN.

Test Plan:
- Zero-wait LW, addr 0x100, ack same cycle, rdata 0xDEADBEEF → DM_addr 0x100, be 1111, STALL_OUT never high, WriteData1_OUT 0xDEADBEEF after 1 edge.
- LB, addr 0x103, ack after 3 cycles, rdata 0x000000F0 → STALL_OUT high 3 cycles, RegWrite1_OUT 0 on stalled edges, then WriteData1_OUT 0xFFFFFFF0; same case as LBU → 0x000000F0.
- SWL addr 0x201, rt 0x11223344 → be 0111, wdata 0x00112233; SWR addr 0x201 → be 1100, wdata 0x33440000; SB addr 0x202, rt 0xAB → be 0010, wdata 0xABABABAB.
- LWL addr 0x302, rt 0xAAAABBBB, rdata 0x12345678 → 0x5678BBBB; LWR addr 0x301 → 0xAAAA1234.
- LW addr 0x402 → no req, Exception_OUT 01, ExceptionPC_OUT = PC, RegWrite1_OUT 0; SH addr 0x401 → 10.
- Ack withheld, TIMEOUT_CYCLES=4 → req dropped after 4 BUSY cycles, Exception_OUT 11, STALL_OUT released; assert RESET during a second BUSY → req low immediately, all outputs 0.
